// File: rtl/alu64.sv
// rtl/alu64.sv - 64-bit registered ALU with negative/zero/overflow/carry flags
// One shared adder serves add and subtract; every output is a flop cleared by async reset.
module alu64 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  cntrl,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  logic        is_sub;
  logic [63:0] b_eff;
  logic [64:0] sum;
  logic        carry_into_msb;

  logic [63:0] result_d, result_q;
  logic        negative_d, negative_q;
  logic        zero_d, zero_q;
  logic        overflow_d, overflow_q;
  logic        carry_out_d, carry_out_q;

  always_comb begin
    is_sub         = (cntrl == OP_SUB);
    b_eff          = is_sub ? ~B : B;
    sum            = {1'b0, A} + {1'b0, b_eff} + {64'd0, is_sub};
    // Carry into bit 63 recovered from the sum bit and the two operand bits.
    carry_into_msb = A[63] ^ b_eff[63] ^ sum[63];

    result_d    = 64'd0;
    overflow_d  = 1'b0;
    carry_out_d = 1'b0;
    case (cntrl)
      OP_PASS_B: result_d = B;
      OP_ADD, OP_SUB: begin
        result_d    = sum[63:0];
        carry_out_d = sum[64];
        overflow_d  = sum[64] ^ carry_into_msb;
      end
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      default: result_d = 64'd0;
    endcase
    negative_d = result_d[63];
    zero_d     = ~|result_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= 64'd0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu64.sv
// tb/tb_alu64.sv - directed self-checking bench for alu64
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_alu64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int errors = 0;
  int checks = 0;

  alu64 dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [63:0] er, input logic ev, input logic ec);
    check({tag, " result"}, result, er);
    check({tag, " negative"}, {63'd0, negative}, {63'd0, er[63]});
    check({tag, " zero"}, {63'd0, zero}, {63'd0, (er == 64'd0)});
    check({tag, " overflow"}, {63'd0, overflow}, {63'd0, ev});
    check({tag, " carry_out"}, {63'd0, carry_out}, {63'd0, ec});
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op, input logic [63:0] er, input logic ev, input logic ec);
    @(negedge clk);
    A = a;
    B = b;
    cntrl = op;
    @(posedge clk);
    #1;
    check_outputs(tag, er, ev, ec);
  endtask

  logic [63:0] pa [7];
  logic [63:0] pb [7];
  logic [2:0]  pop[7];
  logic [63:0] pr [7];
  logic        pv [7];
  logic        pc [7];

  initial begin
    logic [63:0] rb;

    reset = 1'b0;
    A = 64'h1234_5678_9ABC_DEF0;
    B = 64'hFFFF_0000_FFFF_0000;
    cntrl = 3'b010;

    // Asynchronous reset before any rising edge
    #2 reset = 1'b1;
    #1;
    check_outputs("async reset", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset held over edge", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("reset release", 64'd0, 1'b0, 1'b0);
    run_op("add 1+1", 64'd1, 64'd1, 3'b010, 64'd2, 1'b0, 1'b0);

    // PASS_B with random operands, B = 0 included
    for (int i = 0; i < 100; i++) begin
      rb = (i == 7) ? 64'd0 : {$urandom, $urandom};
      run_op("pass_b", {$urandom, $urandom}, rb, 3'b000, rb, 1'b0, 1'b0);
    end

    run_op("add 8+8", 64'h8000000000000000, 64'h8000000000000000, 3'b010, 64'h0, 1'b1, 1'b1);
    run_op("add 4+7", 64'h4000000000000000, 64'h7000000000000000, 3'b010, 64'hB000000000000000, 1'b1, 1'b0);
    run_op("add C+C", 64'hC000000000000000, 64'hC000000000000000, 3'b010, 64'h8000000000000000, 1'b0, 1'b1);

    run_op("sub 1-1", 64'd1, 64'd1, 3'b011, 64'h0, 1'b0, 1'b1);
    run_op("sub B-1", 64'hB000000000000000, 64'h1000000000000000, 3'b011, 64'hA000000000000000, 1'b0, 1'b1);
    run_op("sub 4-8F", 64'h4000000000000000, 64'h8FFFFFFFFFFFFFFF, 3'b011, 64'hB000000000000001, 1'b1, 1'b0);
    run_op("sub small", 64'h000010000C000000, 64'h000070000E000000, 3'b011, 64'hFFFF9FFFFE000000, 1'b0, 1'b0);

    run_op("and", 64'h4000000000000000, 64'h8FFFFFFFFFFFFFFF, 3'b100, 64'h0, 1'b0, 1'b0);
    run_op("or", 64'h4000000000000000, 64'h8FFFFFFFFFFFFFFF, 3'b101, 64'hCFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    run_op("xor", 64'h4000000000000000, 64'h8FFFFFFFFFFFFFFF, 3'b110, 64'hCFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    run_op("xor same", 64'h000010000C000000, 64'h000010000C000000, 3'b110, 64'h0, 1'b0, 1'b0);

    run_op("unused 001", 64'hFFFF, 64'h1234, 3'b001, 64'h0, 1'b0, 1'b0);
    run_op("unused 111", 64'h8000000000000000, 64'h8000000000000000, 3'b111, 64'h0, 1'b0, 1'b0);

    // Back-to-back issue: outputs at each falling edge reflect the previous rising edge
    pa = '{64'd5, 64'd3, 64'hF0, 64'h0, 64'hFF, 64'd1, 64'hFF};
    pb = '{64'd3, 64'd5, 64'h0F, 64'h123, 64'hFF, 64'd1, 64'h0F};
    pop = '{3'b010, 3'b011, 3'b101, 3'b000, 3'b111, 3'b001, 3'b110};
    pr = '{64'd8, 64'hFFFFFFFFFFFFFFFE, 64'hFF, 64'h123, 64'h0, 64'h0, 64'hF0};
    pv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) check_outputs($sformatf("pipe %0d", i - 1), pr[i - 1], pv[i - 1], pc[i - 1]);
      if (i < 7) begin
        A = pa[i];
        B = pb[i];
        cntrl = pop[i];
        #1;
        if (i > 0) check($sformatf("pipe %0d hold", i - 1), result, pr[i - 1]);
      end
    end

    // Reset mid-operation discards the pending result
    run_op("pre-reset add", 64'd40, 64'd2, 3'b010, 64'd42, 1'b0, 1'b0);
    @(negedge clk);
    A = 64'd1;
    B = 64'd1;
    cntrl = 3'b010;
    #2 reset = 1'b1;
    #1;
    check_outputs("mid reset", 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("mid reset held", 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("after reset add", 64'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
